// File: rtl/go_delay_chain.sv
// go_delay_chain: a chain of programmable go-delay stages.
//
// Each stage waits in IDLE for a start. It then counts its sampled delay D
// and pulses done for exactly one cycle, D+1 cycles after the start. A stage
// is started by its own go bit or by the done pulse of any earlier stage.
// A per-stage kill aborts that stage back to IDLE. Kills are recorded in a
// sticky latch, which kill_clr clears.
//
// Optional build macro: GO_DELAY_CHAIN_KILL_BLOCK_EN.
//   When defined, every start (external or cascade) is suppressed while
//   kill_ltchd is set. Stages that are already counting still complete.
//   When undefined, kill_ltchd and kill_src are status only.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   go          per-stage external start
//   kill        per-stage synchronous abort (has priority over start and count)
//   delay_cfg   delay D for stage i in [i*CNT_W +: CNT_W], sampled at start
//   kill_clr    clears kill_src and kill_ltchd
//   busy        stage is in WAIT or DONE
//   done        per-stage one-cycle done pulse
//   done_out    done of the last stage
//   kill_ltchd  sticky: some kill occurred
//   kill_src    sticky per-stage kill flags
module go_delay_chain #(
    parameter int unsigned N_STAGES = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_STAGES-1:0]         go,
    input  logic [N_STAGES-1:0]         kill,
    input  logic [N_STAGES*CNT_W-1:0]   delay_cfg,
    input  logic                        kill_clr,
    output logic [N_STAGES-1:0]         busy,
    output logic [N_STAGES-1:0]         done,
    output logic                        done_out,
    output logic                        kill_ltchd,
    output logic [N_STAGES-1:0]         kill_src
);

    localparam int unsigned CFG_W = N_STAGES * CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [N_STAGES-1:0] start;
    logic                cascade;
    logic [N_STAGES-1:0] kill_src_nxt;

    // Start terms: own go OR any earlier stage's done. Sources merge into one start.
    always_comb begin
        start   = '0;
        cascade = 1'b0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            start[i] = go[i] | cascade;
            cascade  = cascade | done[i];
        end
`ifdef GO_DELAY_CHAIN_KILL_BLOCK_EN
        if (kill_ltchd) begin
            start = '0;
        end
`else
`endif
    end

    // Per-stage FSM with counter; done/busy are registered from the next state.
    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        state_t             state_q;
        logic [CNT_W-1:0]   cnt_q;
        logic               done_q;
        logic               busy_q;
        logic [CNT_W-1:0]   d_cfg;

        assign d_cfg = delay_cfg[g*CNT_W +: CNT_W];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (kill[g]) begin
                // A kill in DONE leaves the current pulse intact; it just ends here.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start[g]) begin
                            busy_q <= 1'b1;
                            if (d_cfg == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                                cnt_q   <= CNT_W'(d_cfg - CNT_W'(1));
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= CNT_W'(cnt_q - CNT_W'(1));
                        end
                    end
                    ST_DONE: begin
                        // Starts arriving in this cycle are dropped.
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign done[g] = done_q;
        assign busy[g] = busy_q;
    end

    assign done_out = done[N_STAGES-1];

    // Sticky kill flags: a new kill wins over a simultaneous clear.
    assign kill_src_nxt = kill | (kill_clr ? {N_STAGES{1'b0}} : kill_src);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_src   <= '0;
            kill_ltchd <= 1'b0;
        end else begin
            kill_src   <= kill_src_nxt;
            kill_ltchd <= |kill_src_nxt;
        end
    end

    // Keeps CFG_W referenced as the documented config bus width.
    logic cfg_w_ok_c;
    assign cfg_w_ok_c = (CFG_W == $bits(delay_cfg));

endmodule
